// File: rtl/clock_pkg.sv
// Shared definitions for the clock user-interface blocks: edit FSM state
// encodings, time field width, field moduli and wrap-around step helpers.
package clock_pkg;

    localparam int TIME_W = 7;

    localparam logic [TIME_W-1:0] HOURS_PER_DAY    = 7'd24;
    localparam logic [TIME_W-1:0] MINUTES_PER_HOUR = 7'd60;

    // Edit FSM encodings; the display mux decodes these raw values.
    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_SET_HOUR = 3'd1;
    localparam logic [2:0] ST_SET_MIN  = 3'd2;
    localparam logic [2:0] ST_ALM_HOUR = 3'd3;
    localparam logic [2:0] ST_ALM_MIN  = 3'd4;

    // Step up with wrap. Anything at or beyond the last legal value lands on 0,
    // which also clamps out-of-range values loaded from the timekeeper.
    function automatic logic [TIME_W-1:0] incWrap(
        input logic [TIME_W-1:0] value,
        input logic [TIME_W-1:0] modulus
    );
        if (value >= modulus - 7'd1) begin
            return '0;
        end
        return value + 7'd1;
    endfunction

    // Step down with wrap. Out-of-range values are clamped to 0 rather than
    // stepped, so a bad load never survives the first adjustment.
    function automatic logic [TIME_W-1:0] decWrap(
        input logic [TIME_W-1:0] value,
        input logic [TIME_W-1:0] modulus
    );
        if (value >= modulus) begin
            return '0;
        end
        if (value == '0) begin
            return modulus - 7'd1;
        end
        return value - 7'd1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Turns one raw asynchronous push button into a single-cycle press pulse:
// 2-flop synchroniser, optional debouncer, registered rising-edge detector.
// Build option: define TSC_DEBOUNCE_EN to include the debouncer.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic sync1Q;
    logic sync2Q;
    logic levelQ;
    logic levelPrevQ;
    logic pressQ;

    // Two-flop synchroniser to bring the raw button into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1Q <= 1'b0;
            sync2Q <= 1'b0;
        end else begin
            sync1Q <= btn_i;
            sync2Q <= sync1Q;
        end
    end

`ifdef TSC_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stableCntQ;

    // Accept a new level only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            levelQ     <= 1'b0;
            stableCntQ <= '0;
        end else if (sync2Q == levelQ) begin
            stableCntQ <= '0;
        end else if (stableCntQ == CNT_LAST) begin
            levelQ     <= sync2Q;
            stableCntQ <= '0;
        end else begin
            stableCntQ <= stableCntQ + 1'b1;
        end
    end
`else
    // Without the debouncer the synchronised level is used directly.
    always_comb begin
        levelQ = sync2Q;
    end
`endif

    // Registered rising-edge detect so the press pulse is glitch-free and
    // lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            levelPrevQ <= 1'b0;
            pressQ     <= 1'b0;
        end else begin
            levelPrevQ <= levelQ;
            pressQ     <= levelQ & ~levelPrevQ;
        end
    end

    assign press_o = pressQ;

endmodule

// File: rtl/time_set_controller.sv
// Front panel controller: conditions four buttons and runs the edit FSM that
// produces time-load strobes and the alarm program for the timekeeping core.
// Build option: define TSC_DEBOUNCE_EN to debounce the buttons.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1250000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_confirm,
    input  logic [6:0]  cur_hour,
    input  logic [6:0]  cur_minute,
    input  logic        alarm_ring,
    output logic [6:0]  setup_hour,
    output logic [6:0]  setup_minute,
    output logic        setup_ready,
    output logic [6:0]  alarm_hour,
    output logic [6:0]  alarm_minute,
    output logic        alarm_ready,
    output logic [6:0]  edit_hour,
    output logic [6:0]  edit_minute,
    output logic [2:0]  mode_state
);

    localparam logic [30:0] TIMEOUT_LAST = 31'(TIMEOUT_CYCLES - 1);

    logic modePress;
    logic upPress;
    logic downPress;
    logic confirmPress;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeBtn (
        .clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(modePress)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUpBtn (
        .clk(clk), .reset(reset), .btn_i(btn_up), .press_o(upPress)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDownBtn (
        .clk(clk), .reset(reset), .btn_i(btn_down), .press_o(downPress)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uConfirmBtn (
        .clk(clk), .reset(reset), .btn_i(btn_confirm), .press_o(confirmPress)
    );

    logic [2:0]        stateQ, stateD;
    logic [TIME_W-1:0] editHourQ, editHourD;
    logic [TIME_W-1:0] editMinuteQ, editMinuteD;
    logic [TIME_W-1:0] setupHourQ, setupHourD;
    logic [TIME_W-1:0] setupMinuteQ, setupMinuteD;
    logic              setupReadyQ, setupReadyD;
    logic [TIME_W-1:0] alarmHourQ, alarmHourD;
    logic [TIME_W-1:0] alarmMinuteQ, alarmMinuteD;
    logic              alarmReadyQ, alarmReadyD;
    logic [30:0]       timerQ, timerD;

    logic anyPress;
    logic stepUp;
    logic stepDown;

    // Press qualification: up and down together cancel each other out.
    always_comb begin
        anyPress = modePress | upPress | downPress | confirmPress;
        stepUp   = upPress & ~downPress;
        stepDown = downPress & ~upPress;
    end

    // Edit FSM next-state: confirm beats mode beats up/down, then the idle
    // timer abandons an edit that nobody touches.
    always_comb begin
        stateD       = stateQ;
        editHourD    = editHourQ;
        editMinuteD  = editMinuteQ;
        setupHourD   = setupHourQ;
        setupMinuteD = setupMinuteQ;
        setupReadyD  = 1'b0;
        alarmHourD   = alarmHourQ;
        alarmMinuteD = alarmMinuteQ;
        alarmReadyD  = alarmReadyQ;
        timerD       = timerQ;

        case (stateQ)
            ST_RUN: begin
                if (confirmPress) begin
                    alarmReadyD = ~alarmReadyQ;
                end else if (modePress) begin
                    stateD      = ST_SET_HOUR;
                    editHourD   = cur_hour;
                    editMinuteD = cur_minute;
                end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
                if (confirmPress) begin
                    setupHourD   = editHourQ;
                    setupMinuteD = editMinuteQ;
                    setupReadyD  = 1'b1;
                    stateD       = ST_RUN;
                end else if (modePress) begin
                    if (stateQ == ST_SET_HOUR) begin
                        stateD = ST_SET_MIN;
                    end else begin
                        stateD      = ST_ALM_HOUR;
                        editHourD   = alarmHourQ;
                        editMinuteD = alarmMinuteQ;
                    end
                end else if (stateQ == ST_SET_HOUR) begin
                    if (stepUp) editHourD = incWrap(editHourQ, HOURS_PER_DAY);
                    else if (stepDown) editHourD = decWrap(editHourQ, HOURS_PER_DAY);
                end else begin
                    if (stepUp) editMinuteD = incWrap(editMinuteQ, MINUTES_PER_HOUR);
                    else if (stepDown) editMinuteD = decWrap(editMinuteQ, MINUTES_PER_HOUR);
                end
            end
            ST_ALM_HOUR, ST_ALM_MIN: begin
                if (confirmPress) begin
                    alarmHourD   = editHourQ;
                    alarmMinuteD = editMinuteQ;
                    alarmReadyD  = 1'b1;
                    stateD       = ST_RUN;
                end else if (modePress) begin
                    stateD = (stateQ == ST_ALM_HOUR) ? ST_ALM_MIN : ST_RUN;
                end else if (stateQ == ST_ALM_HOUR) begin
                    if (stepUp) editHourD = incWrap(editHourQ, HOURS_PER_DAY);
                    else if (stepDown) editHourD = decWrap(editHourQ, HOURS_PER_DAY);
                end else begin
                    if (stepUp) editMinuteD = incWrap(editMinuteQ, MINUTES_PER_HOUR);
                    else if (stepDown) editMinuteD = decWrap(editMinuteQ, MINUTES_PER_HOUR);
                end
            end
            default: begin
                stateD = ST_RUN;
            end
        endcase

        if (stateQ == ST_RUN || anyPress) begin
            timerD = '0;
        end else if (timerQ == TIMEOUT_LAST) begin
            timerD = '0;
            stateD = ST_RUN;
        end else begin
            timerD = timerQ + 31'd1;
        end
    end

    // State and output registers; reset abandons any edit and disarms the alarm.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= ST_RUN;
            editHourQ    <= '0;
            editMinuteQ  <= '0;
            setupHourQ   <= '0;
            setupMinuteQ <= '0;
            setupReadyQ  <= 1'b0;
            alarmHourQ   <= '0;
            alarmMinuteQ <= '0;
            alarmReadyQ  <= 1'b0;
            timerQ       <= '0;
        end else begin
            stateQ       <= stateD;
            editHourQ    <= editHourD;
            editMinuteQ  <= editMinuteD;
            setupHourQ   <= setupHourD;
            setupMinuteQ <= setupMinuteD;
            setupReadyQ  <= setupReadyD;
            alarmHourQ   <= alarmHourD;
            alarmMinuteQ <= alarmMinuteD;
            alarmReadyQ  <= alarmReadyD;
            timerQ       <= timerD;
        end
    end

    assign setup_hour   = setupHourQ;
    assign setup_minute = setupMinuteQ;
    assign setup_ready  = setupReadyQ;
    assign alarm_hour   = alarmHourQ;
    assign alarm_minute = alarmMinuteQ;
    assign alarm_ready  = alarmReadyQ;
    assign edit_hour    = editHourQ;
    assign edit_minute  = editMinuteQ;
    assign mode_state   = stateQ;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed self-checking bench for time_set_controller.
// Build option: define TSC_DEBOUNCE_EN to exercise the debounced build.
module tb_time_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_up, btn_down, btn_confirm;
    logic [6:0] cur_hour, cur_minute;
    logic       alarm_ring;
    logic [6:0] setup_hour, setup_minute, alarm_hour, alarm_minute;
    logic [6:0] edit_hour, edit_minute;
    logic       setup_ready, alarm_ready;
    logic [2:0] mode_state;

    int vectorsApplied = 0;
    int miscompares    = 0;
    int readyPulses    = 0;
    int readyDoubles   = 0;
    int basePulses;
    logic readyPrev    = 1'b0;

`ifdef TSC_DEBOUNCE_EN
    localparam int HOLD_TICKS    = 12;
    localparam int RELEASE_TICKS = 14;
`else
    localparam int HOLD_TICKS    = 2;
    localparam int RELEASE_TICKS = 4;
`endif

    time_set_controller #(
        .DEBOUNCE_CYCLES(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_confirm(btn_confirm),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .alarm_ring(alarm_ring),
        .setup_hour(setup_hour), .setup_minute(setup_minute),
        .setup_ready(setup_ready),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_ready(alarm_ready),
        .edit_hour(edit_hour), .edit_minute(edit_minute),
        .mode_state(mode_state)
    );

    always #5 clk = ~clk;

    // Count strobe cycles and any back-to-back strobes, sampled mid-cycle.
    always @(negedge clk) begin
        if (setup_ready) readyPulses++;
        if (setup_ready && readyPrev) readyDoubles++;
        readyPrev = setup_ready;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorsApplied++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Hold the given buttons, release, and wait for the press to take effect.
    task automatic applyStimulus(input logic confirmB, input logic modeB,
                                 input logic upB, input logic downB);
        btn_confirm = confirmB;
        btn_mode    = modeB;
        btn_up      = upB;
        btn_down    = downB;
        tick(HOLD_TICKS);
        btn_confirm = 1'b0;
        btn_mode    = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        tick(RELEASE_TICKS);
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_confirm = 1'b0;
        cur_hour = 7'd10; cur_minute = 7'd20; alarm_ring = 1'b0;
        tick(3);
        checkOutput("rst_state", int'(mode_state), 0);
        checkOutput("rst_setup_hour", int'(setup_hour), 0);
        checkOutput("rst_setup_minute", int'(setup_minute), 0);
        checkOutput("rst_setup_ready", int'(setup_ready), 0);
        checkOutput("rst_alarm_hour", int'(alarm_hour), 0);
        checkOutput("rst_alarm_minute", int'(alarm_minute), 0);
        checkOutput("rst_alarm_ready", int'(alarm_ready), 0);
        checkOutput("rst_edit_hour", int'(edit_hour), 0);
        checkOutput("rst_edit_minute", int'(edit_minute), 0);
        reset = 1'b0;
        tick(2);

        // Time set: 10:20 -> hour +3, minute -25 -> 13:55.
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1_state_sethour", int'(mode_state), 1);
        checkOutput("t1_load_hour", int'(edit_hour), 10);
        checkOutput("t1_load_minute", int'(edit_minute), 20);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("t1_hour_up3", int'(edit_hour), 13);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1_state_setmin", int'(mode_state), 2);
        for (int i = 0; i < 25; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("t1_minute_down25", int'(edit_minute), 55);
        basePulses = readyPulses;
`ifndef TSC_DEBOUNCE_EN
        btn_confirm = 1'b1;
        tick(3);
        checkOutput("t1_ready_before", int'(setup_ready), 0);
        tick(1);
        checkOutput("t1_ready_at4", int'(setup_ready), 1);
        btn_confirm = 1'b0;
        tick(1);
        checkOutput("t1_ready_after", int'(setup_ready), 0);
        tick(3);
`else
        applyStimulus(1, 0, 0, 0);
`endif
        checkOutput("t1_setup_hour", int'(setup_hour), 13);
        checkOutput("t1_setup_minute", int'(setup_minute), 55);
        checkOutput("t1_one_pulse", readyPulses - basePulses, 1);
        checkOutput("t1_state_run", int'(mode_state), 0);

        // Alarm program: ALM_HOUR starts from 0:00, wrap down to 23:59.
        basePulses = readyPulses;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("t2_state_almhour", int'(mode_state), 3);
        checkOutput("t2_edit_hour0", int'(edit_hour), 0);
        checkOutput("t2_edit_minute0", int'(edit_minute), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_hour_wrap_down", int'(edit_hour), 23);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t2_hour_wrap_up", int'(edit_hour), 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2_state_almmin", int'(mode_state), 4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_minute_wrap_down", int'(edit_minute), 59);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_alarm_hour", int'(alarm_hour), 23);
        checkOutput("t2_alarm_minute", int'(alarm_minute), 59);
        checkOutput("t2_alarm_ready", int'(alarm_ready), 1);
        checkOutput("t2_no_pulse", readyPulses - basePulses, 0);
        checkOutput("t2_setup_held", int'(setup_hour), 13);

        // Dismiss a ringing alarm, then re-arm.
        alarm_ring = 1'b1;
`ifndef TSC_DEBOUNCE_EN
        btn_confirm = 1'b1;
        tick(3);
        checkOutput("t3_ready_before", int'(alarm_ready), 1);
        tick(1);
        checkOutput("t3_disarm_at4", int'(alarm_ready), 0);
        btn_confirm = 1'b0;
        tick(4);
`else
        applyStimulus(1, 0, 0, 0);
        checkOutput("t3_disarm", int'(alarm_ready), 0);
`endif
        alarm_ring = 1'b0;
        applyStimulus(1, 0, 0, 0);
        checkOutput("t3_rearm", int'(alarm_ready), 1);

        // Confirm beats mode; up+down together cancels.
        cur_hour = 7'd5; cur_minute = 7'd7;
        basePulses = readyPulses;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4_state_setmin", int'(mode_state), 2);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t4_confirm_wins_state", int'(mode_state), 0);
        checkOutput("t4_setup_hour", int'(setup_hour), 5);
        checkOutput("t4_setup_minute", int'(setup_minute), 7);
        checkOutput("t4_pulse", readyPulses - basePulses, 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("t4_updown_hour", int'(edit_hour), 5);
        checkOutput("t4_updown_state", int'(mode_state), 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t4_up_after", int'(edit_hour), 6);

        // Idle timeout abandons the edit without a commit.
        basePulses = readyPulses;
        tick(50);
        checkOutput("t5_still_editing", int'(mode_state), 1);
        tick(60);
        checkOutput("t5_timeout_run", int'(mode_state), 0);
        checkOutput("t5_setup_hour_held", int'(setup_hour), 5);
        checkOutput("t5_setup_minute_held", int'(setup_minute), 7);
        checkOutput("t5_no_pulse", readyPulses - basePulses, 0);

        // Out-of-range loads clamp to 0 on the first step.
        cur_hour = 7'd30; cur_minute = 7'd70;
        applyStimulus(0, 1, 0, 0);
        checkOutput("oor_load_hour", int'(edit_hour), 30);
        applyStimulus(0, 0, 0, 1);
        checkOutput("oor_hour_clamp", int'(edit_hour), 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("oor_minute_clamp", int'(edit_minute), 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("almhour_from_alarm", int'(edit_hour), 23);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5_state_almmin", int'(mode_state), 4);

        // Reset mid-edit clears everything.
        reset = 1'b1;
        tick(1);
        checkOutput("t5_rst_state", int'(mode_state), 0);
        checkOutput("t5_rst_alarm_ready", int'(alarm_ready), 0);
        checkOutput("t5_rst_alarm_hour", int'(alarm_hour), 0);
        checkOutput("t5_rst_setup_hour", int'(setup_hour), 0);
        checkOutput("t5_rst_setup_minute", int'(setup_minute), 0);
        checkOutput("t5_rst_edit_hour", int'(edit_hour), 0);
        checkOutput("t5_rst_setup_ready", int'(setup_ready), 0);
        reset = 1'b0;
        tick(2);

`ifdef TSC_DEBOUNCE_EN
        // Short glitch rejected, long press accepted once.
        cur_hour = 7'd10; cur_minute = 7'd20;
        applyStimulus(0, 1, 0, 0);
        checkOutput("t6_state", int'(mode_state), 1);
        btn_up = 1'b1;
        tick(5);
        btn_up = 1'b0;
        tick(20);
        checkOutput("t6_glitch_ignored", int'(edit_hour), 10);
        btn_up = 1'b1;
        tick(12);
        btn_up = 1'b0;
        tick(20);
        checkOutput("t6_long_press", int'(edit_hour), 11);
`endif

        checkOutput("never_double_pulse", readyDoubles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- User-interface front end that produces the time-load and alarm-program inputs for the timekeeping core.
- Conditions four push buttons and runs an edit FSM for the current time or the alarm time.
- Drives setup_hour/setup_minute with a one-cycle setup_ready pulse, and alarm_hour/alarm_minute with a level alarm_ready.
- Also exposes the edit values and the mode so the display mux can show what is being edited.

Parameters:
- DEBOUNCE_CYCLES, 2500000, stable-input cycles needed to accept a button level (20 ms at 125 MHz).
- TIMEOUT_CYCLES, 1250000000, cycles with no accepted press in an edit state before abandoning the edit (10 s at 125 MHz).

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  synchronous, active-high.
- btn_mode  in  1  raw button, asynchronous, active-high.
- btn_up  in  1  raw button, asynchronous, active-high.
- btn_down  in  1  raw button, asynchronous, active-high.
- btn_confirm  in  1  raw button, asynchronous, active-high.
- cur_hour  in  7  live hour from the timekeeper, 0-23.
- cur_minute  in  7  live minute from the timekeeper, 0-59.
- alarm_ring  in  1  alarm currently ringing.
- setup_hour  out  7  hour to load.
- setup_minute  out  7  minute to load.
- setup_ready  out  1  one-cycle load strobe.
- alarm_hour  out  7  programmed alarm hour.
- alarm_minute  out  7  programmed alarm minute.
- alarm_ready  out  1  alarm armed (level).
- edit_hour  out  7  value under edit.
- edit_minute  out  7  value under edit.
- mode_state  out  3  FSM state encoding for the display.

Behaviour:
- Reset: all outputs 0, the FSM in RUN, the timeout counter at 0, and all conditioner state cleared.
- Each button passes through a 2-flop synchroniser, then (optionally) a debouncer, then a rising-edge detector, giving a one-cycle press pulse.
- Without debounce, the press pulse is asserted 3 cycles after the raw input is first sampled high. The action is registered on the following edge, so outputs update 4 cycles after the first sample.
- Same-cycle press priority: confirm > mode > up/down.
- up and down pressed in the same cycle: no change to the edit value.
- FSM states:
  - RUN=0
  - SET_HOUR=1
  - SET_MIN=2
  - ALM_HOUR=3
  - ALM_MIN=4
- RUN:
  - mode -> SET_HOUR; edit_hour/edit_minute <= cur_hour/cur_minute.
  - confirm -> alarm_ready <= ~alarm_ready (arm/disarm; dismisses a ringing alarm).
  - up/down ignored.
- SET_HOUR and ALM_HOUR:
  - up: edit_hour +1, with 23 wrapping to 0.
  - down: edit_hour -1, with 0 wrapping to 23.
- SET_MIN and ALM_MIN:
  - Same as the hour states but on edit_minute, modulo 60 (59 to 0, 0 to 59).
- mode transitions:
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> ALM_HOUR, with edit_hour/edit_minute <= alarm_hour/alarm_minute (the time edit is discarded).
  - ALM_HOUR -> ALM_MIN.
  - ALM_MIN -> RUN (discard).
- confirm in SET_HOUR or SET_MIN:
  - setup_hour/setup_minute <= edit values.
  - setup_ready = 1 for exactly one cycle, coincident with the new setup values.
  - Next state RUN.
- confirm in ALM_HOUR or ALM_MIN:
  - alarm_hour/alarm_minute <= edit values.
  - alarm_ready <= 1.
  - Next state RUN.
- setup_hour/setup_minute and alarm_hour/alarm_minute hold between commits. setup_ready is never high for two consecutive cycles.
- Timeout:
  - The 31-bit counter is cleared on any accepted press and on entering an edit state.
  - In an edit state, reaching TIMEOUT_CYCLES-1 returns the FSM to RUN with no commit and no strobe.
  - The counter is held at 0 in RUN.
- Out-of-range edit values (e.g. loaded from a bad cur_hour) are clamped to 0 on the first up/down.
- Reset mid-edit: return to RUN, no strobe, alarm disarmed.

Optional Feature:
- Macro: TSC_DEBOUNCE_EN.
- Defined:
  - Each synchronised button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  - A glitch shorter than that produces no press.
- Undefined:
  - The debouncer is removed; synchroniser plus edge detect only.
  - DEBOUNCE_CYCLES is ignored.
  - The bench uses this build for cycle-exact checks.

Decomposition:
- Shared package clock_pkg holds:
  - State encodings RUN..ALM_MIN (3-bit).
  - TIME_W=7.
  - HOURS_PER_DAY=24.
  - MINUTES_PER_HOUR=60.
  - Inc/dec-with-wrap functions.
- One sub-module, button_conditioner (sync, optional debounce, rising edge), instantiated four times.

Test Plan:
1. Debounce off, cur=10:20. Press mode, up×3, mode, down×25, confirm:
   - setup_hour=13, setup_minute=55.
   - setup_ready high for exactly 1 cycle.
   - mode_state back to 0.
2. Alarm path: mode×3 (reaching ALM_HOUR, edit=0:00), down, mode, down, confirm:
   - alarm_hour=23, alarm_minute=59, alarm_ready=1.
   - No setup_ready pulse.
3. RUN with alarm_ring=1, alarm_ready=1. Press confirm:
   - alarm_ready=0 four cycles after the press.
   - Press confirm again: alarm_ready=1.
4. In SET_MIN, press confirm and mode in the same cycle:
   - Commit occurs (confirm wins).
   - Press up+down together in SET_HOUR: edit_hour unchanged.
5. Timeout with TIMEOUT_CYCLES=100. Enter SET_HOUR, press up, then idle 100 cycles:
   - mode_state=0, setup outputs unchanged, no setup_ready.
   - Assert reset mid-ALM_MIN edit: all outputs 0.
6. TSC_DEBOUNCE_EN with DEBOUNCE_CYCLES=8:
   - A 5-cycle pulse on btn_up in SET_HOUR leaves edit_hour unchanged.
   - A 12-cycle pulse increments edit_hour once.
